writeback_arbiter: RTL and testbench

Merges register-file write requests from the ALU and the load unit into the register file's single write port (`write`, `WriteRegID`, `WriteData`). Each source has a 2-entry buffer. A round-robin arbiter issues at most one write per cycle. Writes to register 0 and to out-of-range IDs are filtered and counted. Sits directly upstream of the register file, between the execute/memory stages and the write port.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_fifo2.sv | 32 +++
 rtl/writeback_arbiter.sv | 65 ++++++
 tb/tb_writeback_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, entry type and register-id legality check for the writeback arbiter
package wb_pkg;
  localparam int DATA_W = 32;
  localparam int ID_W = 6;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
  function automatic logic wb_id_legal(input logic [31:0] id, input int num_regs = NUM_REGS);
    return id != 32'd0 && id < 32'(num_regs);
  endfunction
endpackage

// File: rtl/wb_fifo2.sv
// wb_fifo2: in-order 2-entry fifo with count and full/empty flags, push and pop allowed together
module wb_fifo2 #(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic rd, wr;
  assign full = count == 2'd2;
  assign empty = count == 2'd0;
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      count <= 2'd0;
      rd <= 1'b0;
      wr <= 1'b0;
    end else begin
      if (push) wr <= ~wr;
      if (pop) rd <= ~rd;
      count <= count + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin merge of alu and load writebacks into one filtered register-file write port
module writeback_arbiter #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ID_W = wb_pkg::ID_W,
  parameter int NUM_REGS = wb_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ID_W-1:0]   alu_id,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ID_W-1:0]   mem_id,
  input  logic [DATA_W-1:0] mem_data,
  output logic              write,
  output logic [ID_W-1:0]   WriteRegID,
  output logic [DATA_W-1:0] WriteData,
  output logic [7:0]        drop_cnt,
  output logic              busy
);
  import wb_pkg::*;
  localparam int W = ID_W + DATA_W;
  logic [W-1:0] a_dout, m_dout;
  logic [1:0] a_cnt, m_cnt;
  logic a_full, a_empty, m_full, m_empty;
  logic rr, ga, gm, grant, legal;
  logic [ID_W-1:0] hid;
  logic [DATA_W-1:0] hdata;
  assign alu_ready = ~a_full;
  assign mem_ready = ~m_full;
  assign busy = |a_cnt | |m_cnt;
  wb_fifo2 #(.W(W)) u_alu (
    .clk(clk), .rst(rst), .push(alu_valid & alu_ready), .pop(ga), .din({alu_id, alu_data}),
    .dout(a_dout), .count(a_cnt), .full(a_full), .empty(a_empty)
  );
  wb_fifo2 #(.W(W)) u_mem (
    .clk(clk), .rst(rst), .push(mem_valid & mem_ready), .pop(gm), .din({mem_id, mem_data}),
    .dout(m_dout), .count(m_cnt), .full(m_full), .empty(m_empty)
  );
  always_comb begin
    ga = ~a_empty & (m_empty | ~rr);
    gm = ~m_empty & ~ga;
    grant = ga | gm;
    {hid, hdata} = ga ? a_dout : m_dout;
    legal = wb_id_legal(32'(hid), NUM_REGS);
  end
  always_ff @(posedge clk)
    if (rst) begin
      rr <= 1'b0;
      write <= 1'b0;
      WriteRegID <= '0;
      WriteData <= '0;
      drop_cnt <= 8'd0;
    end else begin
      if (~a_empty & ~m_empty) rr <= ~rr;
      write <= grant & legal;
      if (grant & legal) begin
        WriteRegID <= hid;
        WriteData <= hdata;
      end
      if (grant & ~legal & drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed scoreboard bench for writeback_arbiter
module tb_writeback_arbiter;
  typedef struct {
    logic [5:0] id;
    logic [31:0] data;
  } ent_t;
  logic clk, rst, alu_valid, mem_valid, alu_ready, mem_ready, write, busy;
  logic [5:0] alu_id, mem_id, WriteRegID;
  logic [31:0] alu_data, mem_data, WriteData;
  logic [7:0] drop_cnt;
  int total, bad, cyc, e_drop;
  bit m_rr, e_w, hs_a, hs_m, saw_alu_full;
  logic [5:0] e_id;
  logic [31:0] e_data;
  ent_t qa[$], qm[$];
  logic [5:0] ai_q[$], mi_q[$], wlog[$];
  int wcyc[$];
  writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_id(alu_id), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_id(mem_id), .mem_data(mem_data),
    .write(write), .WriteRegID(WriteRegID), .WriteData(WriteData), .drop_cnt(drop_cnt), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    bit ga, gm, ha, hm;
    ent_t e;
    ha = alu_valid && alu_ready;
    hm = mem_valid && mem_ready;
    if (rst) begin
      qa.delete();
      qm.delete();
      m_rr = 0;
      e_w = 0;
      e_id = '0;
      e_data = '0;
      e_drop = 0;
      ha = 0;
      hm = 0;
    end else begin
      chk("alu_ready", alu_ready, qa.size() != 2);
      chk("mem_ready", mem_ready, qm.size() != 2);
      if (!alu_ready) saw_alu_full = 1;
      ga = qa.size() > 0 && (qm.size() == 0 || !m_rr);
      gm = qm.size() > 0 && !ga;
      if (qa.size() > 0 && qm.size() > 0) m_rr = !m_rr;
      e_w = 0;
      if (ga || gm) begin
        e = ga ? qa.pop_front() : qm.pop_front();
        if (e.id != 0 && e.id < 32) begin
          e_w = 1;
          e_id = e.id;
          e_data = e.data;
        end else if (e_drop != 255) e_drop++;
      end
      if (ha) begin
        e.id = alu_id;
        e.data = alu_data;
        qa.push_back(e);
      end
      if (hm) begin
        e.id = mem_id;
        e.data = mem_data;
        qm.push_back(e);
      end
    end
    hs_a = ha;
    hs_m = hm;
    @(posedge clk);
    #1;
    cyc++;
    chk("write", write, e_w);
    chk("WriteRegID", WriteRegID, e_id);
    chk("WriteData", WriteData, e_data);
    chk("drop_cnt", drop_cnt, e_drop);
    chk("busy", busy, qa.size() + qm.size() != 0);
    if (write) begin
      wlog.push_back(WriteRegID);
      wcyc.push_back(cyc);
    end
  endtask
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic stream();
    int ia, im, budget;
    ia = 0;
    im = 0;
    budget = 0;
    while ((ia < ai_q.size() || im < mi_q.size()) && budget < 2000) begin
      alu_valid = ia < ai_q.size();
      alu_id = alu_valid ? ai_q[ia] : 6'd0;
      alu_data = alu_valid ? (32'hA000_0000 | 32'($urandom_range(0, 65535))) : 32'd0;
      mem_valid = im < mi_q.size();
      mem_id = mem_valid ? mi_q[im] : 6'd0;
      mem_data = mem_valid ? (32'hB000_0000 | 32'($urandom_range(0, 65535))) : 32'd0;
      tick();
      if (hs_a) ia++;
      if (hs_m) im++;
      budget++;
    end
    if (budget >= 2000) chk("stream_timeout", 1, 0);
    alu_valid = 0;
    mem_valid = 0;
    ai_q.delete();
    mi_q.delete();
  endtask
  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    rst = 1;
    alu_valid = 0;
    mem_valid = 0;
    alu_id = '0;
    mem_id = '0;
    alu_data = '0;
    mem_data = '0;
    drain(2);
    rst = 0;
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_busy", busy, 0);
    alu_valid = 1;
    alu_id = 6'd5;
    alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 0;
    chk("t1_no_write_at_k", write, 0);
    tick();
    chk("t1_write", write, 1);
    chk("t1_id", WriteRegID, 6'd5);
    chk("t1_data", WriteData, 32'hDEADBEEF);
    tick();
    chk("t1_write_once", write, 0);
    chk("t1_idle", busy, 0);
    wlog.delete();
    ai_q = {6'd1, 6'd2, 6'd3};
    mi_q = {6'd11, 6'd12, 6'd13};
    stream();
    drain(5);
    chk("t2_count", wlog.size(), 6);
    if (wlog.size() == 6) begin
      logic [5:0] exp_ord [6];
      exp_ord = '{6'd1, 6'd11, 6'd2, 6'd12, 6'd3, 6'd13};
      for (int i = 0; i < 6; i++) chk("t2_order", wlog[i], exp_ord[i]);
    end
    wlog.delete();
    saw_alu_full = 0;
    ai_q = {6'd21, 6'd22, 6'd23, 6'd24};
    mi_q = {6'd25, 6'd26, 6'd27, 6'd28};
    stream();
    drain(6);
    chk("t3_alu_full_seen", saw_alu_full, 1);
    chk("t3_count", wlog.size(), 8);
    wlog.delete();
    wcyc.delete();
    ai_q = {6'd7, 6'd8, 6'd9, 6'd10};
    stream();
    drain(3);
    chk("t4_count", wcyc.size(), 4);
    for (int i = 0; i + 1 < wcyc.size(); i++) chk("t4_no_bubble", wcyc[i+1] - wcyc[i], 1);
    wlog.delete();
    ai_q = {6'd0, 6'd32, 6'd63};
    stream();
    drain(3);
    chk("t5_drop3", drop_cnt, 8'd3);
    chk("t5_no_writes", wlog.size(), 0);
    for (int i = 0; i < 130; i++) begin
      ai_q.push_back(i[0] ? 6'd0 : 6'd40);
      mi_q.push_back(i[0] ? 6'd33 : 6'd0);
    end
    stream();
    drain(4);
    chk("t5_saturate", drop_cnt, 8'd255);
    chk("t5_no_writes_flood", wlog.size(), 0);
    ai_q = {6'd1, 6'd2};
    mi_q = {6'd3, 6'd4};
    stream();
    chk("t6_busy_before_rst", busy, 1);
    rst = 1;
    tick();
    rst = 0;
    wlog.delete();
    chk("t6_busy", busy, 0);
    chk("t6_alu_ready", alu_ready, 1);
    chk("t6_mem_ready", mem_ready, 1);
    chk("t6_drop_clr", drop_cnt, 0);
    drain(3);
    chk("t6_no_write", wlog.size(), 0);
    ai_q = {6'd6};
    mi_q = {6'd16};
    stream();
    drain(3);
    chk("t6_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t6_alu_first", wlog[0], 6'd6);
      chk("t6_mem_second", wlog[1], 6'd16);
    end
    wlog.delete();
    ai_q = {6'd0, 6'd4};
    mi_q = {6'd40, 6'd14};
    stream();
    drain(4);
    chk("t7_drops", drop_cnt, 8'd2);
    chk("t7_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t7_first", wlog[0], 6'd14);
      chk("t7_second", wlog[1], 6'd4);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
